// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the radix-16 Booth multiplier datapath.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    ISSUE   = 2'd2,
    DONE    = 2'd3
  } booth_state_e;

  // Recoded radix-16 digit, range -8..+8.
  typedef logic signed [4:0] booth_digit_t;

  function automatic int booth_r16_ndig(input int width);
    return (width + 3) / 4;
  endfunction

  // Four extra bits hold the full range of +/-8M, including +8 * 2^(width-1).
  function automatic int booth_r16_ppw(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/booth_r16_digit_sel.sv
// Radix-16 Booth digit recoder and multiple selector: maps a 5-bit window
// {y[3:0], y[-1]} to d*M using the precomputed odd multiples.
module booth_r16_digit_sel
  import mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PP_W  = booth_r16_ppw(WIDTH)
) (
  input  logic [4:0]       i_window,
  input  logic [WIDTH-1:0] i_m,
  input  logic [PP_W-1:0]  i_m3,
  input  logic [PP_W-1:0]  i_m5,
  input  logic [PP_W-1:0]  i_m7,
  output logic [PP_W-1:0]  o_pp_data
);

  booth_digit_t    w_digit;
  logic            w_neg;
  logic [3:0]      w_mag;
  logic [PP_W-1:0] w_m1;
  logic [PP_W-1:0] w_sel;

  // Top four window bits read as a signed nibble, plus the guard bit.
  assign w_digit = booth_digit_t'({i_window[4], i_window[4:1]})
                 + booth_digit_t'({4'b0000, i_window[0]});
  assign w_neg   = w_digit[4];
  assign w_mag   = 4'(w_neg ? -w_digit : w_digit);
  assign w_m1    = PP_W'($signed(i_m));

  always_comb begin
    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    w_sel = '0;
    case (w_mag)
      4'd1:    w_sel = w_m1;
      4'd2:    w_sel = w_m1 << 1;
      4'd3:    w_sel = i_m3;
      4'd4:    w_sel = w_m1 << 2;
      4'd5:    w_sel = i_m5;
      4'd6:    w_sel = i_m3 << 1;
      4'd7:    w_sel = i_m7;
      4'd8:    w_sel = w_m1 << 3;
      default: w_sel = '0;
    endcase
  end

  assign o_pp_data = w_neg ? -w_sel : w_sel;

endmodule

// File: rtl/booth_r16_pp_gen.sv
// Sequential radix-16 Booth partial-product generator: one signed d_i*M beat
// per accepted handshake, least-significant digit first.
module booth_r16_pp_gen
  import mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int NDIG  = booth_r16_ndig(WIDTH),
  localparam int PP_W  = booth_r16_ppw(WIDTH),
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             pp_valid,
  input  logic             pp_ready,
  output logic [PP_W-1:0]  pp_data,
  output logic [IDX_W-1:0] pp_idx,
  output logic             pp_last,
  output logic             done
);

  localparam int YQ_W = 4 * NDIG;

  booth_state_e     r_state;
  booth_state_e     w_next;
  logic [WIDTH-1:0] r_m_q;
  logic [YQ_W-1:0]  r_y_q;
  logic             r_g_q;
  logic [IDX_W-1:0] r_idx;
  logic [PP_W-1:0]  r_m3;
  logic [PP_W-1:0]  r_m5;
  logic [PP_W-1:0]  r_m7;

  logic             w_accept;
  logic             w_fire;
  logic             w_last;
  logic [PP_W-1:0]  w_m_ext;
  logic [PP_W-1:0]  w_pp;

  assign w_accept = (r_state == IDLE) && start;
  assign w_fire   = pp_valid && pp_ready;
  assign w_last   = (r_idx == IDX_W'(NDIG - 1));
  assign w_m_ext  = PP_W'($signed(r_m_q));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    pp_valid = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = PRECOMP;
      PRECOMP: begin
        busy   = 1'b1;
        w_next = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        pp_valid = 1'b1;
        if (pp_ready && w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is cleared so an aborted run leaves no
    // stale operand behind for the next launch.
    if (!rst_n) begin
      r_m_q <= '0;
      r_y_q <= '0;
      r_g_q <= 1'b0;
      r_idx <= '0;
      r_m3  <= '0;
      r_m5  <= '0;
      r_m7  <= '0;
    end else begin
      if (w_accept) begin
        r_m_q <= multiplicand;
        r_y_q <= YQ_W'($signed(multiplier));
        r_g_q <= 1'b0;
        r_idx <= '0;
      end
      if (r_state == PRECOMP) begin
        r_m3 <= (w_m_ext << 1) + w_m_ext;
        r_m5 <= (w_m_ext << 2) + w_m_ext;
        r_m7 <= (w_m_ext << 3) - w_m_ext;
      end
      // The retired top bit becomes the guard bit of the next window.
      if (w_fire && !w_last) begin
        r_g_q <= r_y_q[3];
        r_y_q <= YQ_W'($signed(r_y_q) >>> 4);
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  booth_r16_digit_sel #(
    .WIDTH(WIDTH)
  ) u_digit_sel (
    .i_window  ({r_y_q[3:0], r_g_q}),
    .i_m       (r_m_q),
    .i_m3      (r_m3),
    .i_m5      (r_m5),
    .i_m7      (r_m7),
    .o_pp_data (w_pp)
  );

  // Beat fields are forced to zero outside ISSUE so idle outputs stay quiet.
  assign pp_data = pp_valid ? w_pp  : '0;
  assign pp_idx  = pp_valid ? r_idx : '0;
  assign pp_last = pp_valid && w_last;

endmodule

// File: doc/booth_r16_pp_gen.md
Name: booth_r16_pp_gen

Overview:
- Sequential radix-16 Booth partial-product generator.
- Sits directly downstream of the multiplicand register: it samples the registered multiplicand and the multiplier on start.
- Precomputes the odd multiples 3M, 5M and 7M, then walks the multiplier 4 bits per beat.
- Emits one signed partial product per beat over a valid/ready handshake to the accumulator stage.

Parameters:
- WIDTH, 8, operand width in bits; both operands are signed two's complement.
- NDIG, (WIDTH+3)/4, number of radix-16 digits. Derived; must not be overridden.
- PP_W, WIDTH+4, partial-product width. It holds the full range ±8M, including +8·2^(WIDTH-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; honoured only in IDLE
- multiplicand  in  WIDTH  M, sampled on an accepted start
- multiplier  in  WIDTH  Y, sampled on an accepted start
- busy  out  1  high in every state except IDLE
- pp_valid  out  1  partial product available
- pp_ready  in  1  consumer accepts the beat
- pp_data  out  PP_W  signed partial product d_i·M
- pp_idx  out  $clog2(NDIG) (minimum 1)  digit index i; weight is 2^(4i)
- pp_last  out  1  high with the final beat (i = NDIG-1)
- done  out  1  single-cycle pulse after the last beat is accepted

Behaviour:
- Reset: the asynchronous assert forces IDLE and clears every register. All outputs are 0 while rst_n is low and in the first cycle after release. Reset mid-operation aborts silently: no done pulse, and the partial sequence is discarded.
- FSM is IDLE -> PRECOMP -> ISSUE -> DONE -> IDLE.
- IDLE:
  - start=1 latches M into m_q.
  - It latches Y, sign-extended to 4·NDIG bits, into y_q, with a guard bit g_q=0 (this is y[-1]).
  - It clears idx and moves to PRECOMP.
  - start in any other state is ignored and has no side effects.
- PRECOMP (exactly 1 cycle):
  - Register m3 = 3M, m5 = 5M and m7 = 7M, each sign-extended to PP_W.
  - Then go to ISSUE.
- ISSUE:
  - Digit d = -8·y_q[3] + 4·y_q[2] + 2·y_q[1] + y_q[0] + g_q, range -8..+8.
  - pp_data = d·M in PP_W bits. |d| selects from {0, M, 2M, 3M, 4M, 5M, 6M, 7M, 8M}, where the even multiples are shifts of M or m3. A negative d uses full two's-complement negation.
  - pp_valid=1. pp_idx=idx. pp_last = (idx == NDIG-1).
  - While pp_valid && !pp_ready, pp_data, pp_idx and pp_last must be held stable.
  - On pp_valid && pp_ready:
    - If not last: g_q <= y_q[3], y_q <= y_q >>> 4 (arithmetic shift), idx++.
    - If last: go to DONE.
- DONE (1 cycle): done=1, pp_valid=0, busy=1. Then go to IDLE.
  - A start in this cycle is ignored.
  - The earliest relaunch is the cycle after, in IDLE.
- Latency, with start at cycle 0 and pp_ready held high:
  - pp_valid asserts at cycles 2 .. NDIG+1.
  - done pulses at cycle NDIG+2.
  - busy is high for cycles 1 .. NDIG+2.
- Correctness invariant: Σ pp_data_i·2^(4i) = M·Y exactly, evaluated in 2·WIDTH+4 bits.
- No output depends combinationally on pp_ready.

Decomposition:
- mul_pkg:
  - booth_state_e enum {IDLE, PRECOMP, ISSUE, DONE}.
  - Function booth_r16_ndig(width).
  - Function booth_r16_ppw(width).
  - booth_digit_t, a signed 5-bit type.
- Sub-module booth_r16_digit_sel: combinational. It takes the 5-bit window plus M, m3, m5 and m7, and returns pp_data. It is reused by a future parallel array.
- Odd-multiple adders stay in the top module.

Test Plan (WIDTH=8, NDIG=2, PP_W=12):
1. M=3, Y=5, ready=1 -> beats (idx0, pp=15), then (idx1, pp=0, last=1). done at cycle 4, and 15 + 0·16 = 15.
2. M=5, Y=0x77 (119) -> pp0=35, pp1=35. Sum 35 + 560 = 595.
3. M=-128 (0x80), Y=-128 (0x80) -> pp0=0, pp1=+1024 (0x400). Sum 16384; this checks the PP_W headroom.
4. M=7, Y=-1 (0xFF) -> pp0=-7 (0xFF9), pp1=0. Hold pp_ready=0 for 3 cycles on each beat; pp_data and pp_idx must stay stable and the beats still complete in order.
5. Assert start again during PRECOMP and ISSUE with different operands -> ignored, and results still match test 1.
6. Pulse rst_n low for 1 cycle while in ISSUE at idx0 -> all outputs 0 and no done pulse. A new start with M=2, Y=3 then yields pp0=6, pp1=0.
